// File: rtl/wb_pwm_capture.sv
// RC PWM high-time capture (us units) behind a Wishbone B4 classic slave.
// Response one cycle after request, no wait states; pin to edge detect is 3 cycles.
module wb_pwm_capture #(
    parameter int NUM_CH     = 6,
    parameter int CLK_DIV    = 72,
    parameter int MIN_US     = 800,
    parameter int MAX_US     = 2200,
    parameter int TIMEOUT_US = 25000
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    input  logic [NUM_CH-1:0] i_pwm
);
    localparam int          PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [15:0] MIN_W = 16'(MIN_US);
    localparam logic [15:0] MAX_W = 16'(MAX_US);
    localparam logic [15:0] TO_W  = 16'(TIMEOUT_US);

    typedef enum logic {IDLE, HIGH} ch_state_t;

    logic [PW-1:0]     presc;
    logic              tick;
    logic [NUM_CH-1:0] sync1, sync2, prev, armed, rise, fall;
    logic [1:0]        fill;
    ch_state_t         state  [NUM_CH];
    logic [15:0]       hi_cnt [NUM_CH];
    logic [15:0]       width  [NUM_CH];
    logic [15:0]       age    [NUM_CH];
    logic [NUM_CH-1:0] valid, err, in_range, err_set, err_clr;
    logic              enable;
    logic              req, wr_ch;
    logic [2:0]        idx;
    logic [31:0]       rdata;
    logic [5:0]        valid6, err6;
    logic              unused_ok;

    assign unused_ok = ^{wb_sel_i, wb_adr_i, wb_dat_i};

    assign tick = (presc == PW'(CLK_DIV - 1));

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) presc <= '0;
        else           presc <= tick ? '0 : presc + PW'(1);
    end

    // A channel only arms after the synchroniser holds real pin data and shows
    // the pin low, so a pulse already in flight at reset release is discarded.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            armed <= '0;
            fill  <= '0;
        end else begin
            sync1 <= i_pwm;
            sync2 <= sync1;
            prev  <= sync2;
            if (fill != 2'd3) fill <= fill + 2'd1;
            armed <= armed | ({NUM_CH{fill == 2'd3}} & ~sync2);
        end
    end

    assign rise = sync2 & ~prev & armed;
    assign fall = ~sync2 & prev;

    always_comb begin
        in_range = '0;
        err_set  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            in_range[i] = (hi_cnt[i] >= MIN_W) && (hi_cnt[i] <= MAX_W);
            err_set[i]  = enable && (state[i] == HIGH) && fall[i] && !in_range[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            valid <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]  <= IDLE;
                hi_cnt[i] <= '0;
                width[i]  <= '0;
                age[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!enable) begin
                    state[i] <= IDLE;
                    width[i] <= '0;
                    valid[i] <= 1'b0;
                    age[i]   <= '0;
                end else begin
                    if (tick && age[i] != 16'hFFFF) age[i] <= age[i] + 16'd1;
                    if (age[i] >= TO_W) begin
                        valid[i] <= 1'b0;
                        width[i] <= '0;
                    end
                    case (state[i])
                        IDLE: if (rise[i]) begin
                            hi_cnt[i] <= '0;
                            state[i]  <= HIGH;
                        end
                        HIGH: begin
                            if (tick && hi_cnt[i] != 16'hFFFF) hi_cnt[i] <= hi_cnt[i] + 16'd1;
                            if (fall[i]) begin
                                state[i] <= IDLE;
                                // Later assignments override the timeout clear and age tick.
                                if (in_range[i]) begin
                                    width[i] <= hi_cnt[i];
                                    valid[i] <= 1'b1;
                                    age[i]   <= '0;
                                end
                            end
                        end
                        default: state[i] <= IDLE;
                    endcase
                end
            end
        end
    end

    assign req   = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign idx   = wb_adr_i[4:2];
    assign wr_ch = wb_we_i && (idx <= 3'd5);

    always_comb begin
        valid6                = '0;
        err6                  = '0;
        valid6[NUM_CH-1:0]    = valid;
        err6[NUM_CH-1:0]      = err;
        err_clr               = '0;
        if (req && wb_we_i && idx == 3'd6) err_clr = wb_dat_i[8 +: NUM_CH];
        rdata = '0;
        case (idx)
            3'd6:    rdata = {18'h0, err6, 2'b00, valid6};
            3'd7:    rdata = {31'h0, enable};
            default: begin
                for (int i = 0; i < NUM_CH; i++)
                    if (idx == 3'(i)) rdata = {16'h0, width[i]};
            end
        endcase
    end

    // Read data is captured at the request edge, so it is the pre-update value.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            enable   <= 1'b1;
            err      <= '0;
        end else begin
            wb_ack_o <= req & ~wr_ch;
            wb_err_o <= req & wr_ch;
            if (req) wb_dat_o <= wb_we_i ? 32'h0 : rdata;
            if (req && wb_we_i && idx == 3'd7) enable <= wb_dat_i[0];
            err <= (err & ~err_clr) | err_set;
        end
    end
endmodule

// File: tb/tb_wb_pwm_capture.sv
`timescale 1ns/1ps
module tb_wb_pwm_capture;
    localparam int NUM_CH = 6, CLK_DIV = 4, MIN_US = 800, MAX_US = 2200, TIMEOUT_US = 3000;
    localparam longint THR = TIMEOUT_US * CLK_DIV;

    logic              i_clk = 1'b0, i_resetn = 1'b1;
    logic [31:0]       wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
    logic              wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0;
    logic [3:0]        wb_sel_i = 4'hF;
    logic              wb_ack_o, wb_err_o;
    logic [NUM_CH-1:0] i_pwm = '0;

    int     n_cmp = 0, n_bad = 0;
    longint cyc = 0, last_fall = 0;

    // reference model for the randomized rounds
    longint     last_end [NUM_CH];
    bit         has_v    [NUM_CH];
    int         exp_w    [NUM_CH];
    logic [5:0] exp_err, expv, mask;
    int         len [NUM_CH], st [NUM_CH], ex;
    longint     t0;
    logic [31:0] d;

    wb_pwm_capture #(.NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .MIN_US(MIN_US),
                     .MAX_US(MAX_US), .TIMEOUT_US(TIMEOUT_US)) dut (
        .i_clk(i_clk), .i_resetn(i_resetn), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i),
        .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .i_pwm(i_pwm));

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [31:0] obs, input int exp_us);
        logic ok;
        int   v;
        v  = int'(obs[15:0]);
        ok = (obs[31:16] == 16'h0) && (v >= exp_us - 1) && (v <= exp_us + 1);
        n_cmp++;
        assert (ok === 1'b1) else begin
            n_bad++;
            $error("FAIL %s: observed %0d (raw %h) expected %0d +/-1", tag, v, obs, exp_us);
        end
    endtask

    task automatic wb_xfer(input logic we, input int idx, input logic [31:0] wd,
                           input logic exp_err_rsp, output logic [31:0] rd);
        @(negedge i_clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = 32'(idx) << 2; wb_dat_i = wd;
        @(negedge i_clk);
        check($sformatf("ack_%0d", idx), {31'h0, wb_ack_o}, {31'h0, !exp_err_rsp});
        check($sformatf("err_%0d", idx), {31'h0, wb_err_o}, {31'h0, exp_err_rsp});
        rd = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge i_clk);
        check("rsp_single_cycle", {30'h0, wb_ack_o, wb_err_o}, 32'h0);
    endtask

    task automatic rd(input int idx, output logic [31:0] data);
        wb_xfer(1'b0, idx, 32'h0, 1'b0, data);
    endtask

    task automatic wr(input int idx, input logic [31:0] data);
        logic [31:0] dummy;
        wb_xfer(1'b1, idx, data, idx < 6, dummy);
    endtask

    task automatic pulse(input int ch, input int us);
        @(negedge i_clk);
        i_pwm[ch] = 1'b1;
        repeat (us * CLK_DIV) @(negedge i_clk);
        i_pwm[ch] = 1'b0;
        last_fall = cyc;
        repeat (8) @(negedge i_clk);
    endtask

    // 0 = invalid, 1 = valid, 2 = too close to the timeout edge to judge
    task automatic exp_state(input int ch, output int s);
        longint el;
        el = cyc - last_end[ch];
        if (!has_v[ch])          s = 0;
        else if (el < THR - 60)  s = 1;
        else if (el > THR + 60)  s = 0;
        else                     s = 2;
    endtask

    task automatic wait_until(input longint target);
        while (cyc < target) @(negedge i_clk);
    endtask

    initial begin
        // reset values
        #1 i_resetn = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_ack", {31'h0, wb_ack_o}, 32'h0);
        check("rst_err", {31'h0, wb_err_o}, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        i_resetn = 1'b1;
        rd(0, d); check("rst_ch0", d, 32'h0);
        rd(6, d); check("rst_status", d, 32'h0);
        rd(7, d); check("rst_ctrl", d, 32'h1);

        // 1500 us on ch0
        pulse(0, 1500);
        rd(0, d); check_w("t1_ch0", d, 1500);
        rd(6, d); check("t1_valid0", {31'h0, d[0]}, 32'h1);
        check("t1_err0", {31'h0, d[8]}, 32'h0);

        // valid 1000 then short 500 on ch2
        pulse(2, 1000);
        pulse(2, 500);
        rd(2, d); check_w("t2_ch2", d, 1000);
        rd(6, d); check("t2_err2", {31'h0, d[10]}, 32'h1);

        // disable: widths and valid cleared, err retained, pulses ignored
        wr(7, 32'h0);
        for (int i = 0; i < NUM_CH; i++) begin
            rd(i, d); check($sformatf("dis_ch%0d", i), d, 32'h0);
        end
        rd(6, d); check("dis_status", d, 32'h400);
        pulse(0, 1000);
        rd(0, d); check("dis_ch0_ign", d, 32'h0);
        rd(6, d); check("dis_status2", d, 32'h400);
        wr(6, 32'h400);
        rd(6, d); check("w1c_status", d, 32'h0);
        wr(7, 32'h1);
        rd(7, d); check("ctrl_on", d, 32'h1);
        pulse(0, 2000);
        rd(0, d); check_w("en_ch0", d, 2000);

        // write to a width register is rejected
        wr(3, 32'h1234);
        rd(3, d); check("ch3_unchanged", d, 32'h0);
        rd(7, d); check("ctrl_read", d, 32'h1);

        // timeout on ch1
        pulse(1, 1200);
        rd(1, d); check_w("t3_ch1", d, 1200);
        wait_until(last_fall + THR - 40);
        rd(6, d); check("t3_pre_valid1", {31'h0, d[1]}, 32'h1);
        wait_until(last_fall + THR + 12);
        rd(6, d); check("t3_post_valid1", {31'h0, d[1]}, 32'h0);
        rd(1, d); check("t3_post_ch1", d, 32'h0);

        // reset in the middle of a pulse
        @(negedge i_clk);
        i_pwm[0] = 1'b1;
        repeat (750 * CLK_DIV) @(negedge i_clk);
        i_resetn = 1'b0;
        #1;
        check("mid_rst_ack", {31'h0, wb_ack_o}, 32'h0);
        check("mid_rst_err", {31'h0, wb_err_o}, 32'h0);
        check("mid_rst_dat", wb_dat_o, 32'h0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_resetn = 1'b1;
        repeat (750 * CLK_DIV) @(negedge i_clk);
        i_pwm[0] = 1'b0;
        repeat (8) @(negedge i_clk);
        rd(0, d); check("mid_rst_ch0", d, 32'h0);
        rd(6, d); check("mid_rst_status", d, 32'h0);
        rd(7, d); check("mid_rst_ctrl", d, 32'h1);
        pulse(0, 1500);
        rd(0, d); check_w("post_rst_ch0", d, 1500);
        rd(6, d); check("post_rst_status", d, 32'h1);

        // randomized parallel rounds against the reference model
        for (int c = 0; c < NUM_CH; c++) begin
            has_v[c] = 1'b0; exp_w[c] = 0; last_end[c] = 0;
        end
        has_v[0] = 1'b1; exp_w[0] = 1500; last_end[0] = last_fall;
        exp_err = '0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                len[c] = int'($urandom_range(600, 2400));
                if (len[c] >= 795 && len[c] <= 805)   len[c] += 20;
                if (len[c] >= 2195 && len[c] <= 2205) len[c] -= 20;
                if ($urandom_range(0, 4) == 0)        len[c] = 0;
                st[c] = int'($urandom_range(0, 160));
            end
            t0 = 0;
            for (int k = 0; k < 2450 * CLK_DIV; k++) begin
                @(negedge i_clk);
                if (k == 0) t0 = cyc;
                for (int c = 0; c < NUM_CH; c++)
                    i_pwm[c] = (len[c] != 0) && (k >= st[c]) && (k < st[c] + len[c] * CLK_DIV);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (len[c] == 0) continue;
                if (len[c] >= MIN_US && len[c] <= MAX_US) begin
                    has_v[c]    = 1'b1;
                    exp_w[c]    = len[c];
                    last_end[c] = t0 + st[c] + len[c] * CLK_DIV;
                end else begin
                    exp_err[c] = 1'b1;
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                exp_state(c, ex);
                rd(c, d);
                if (ex == 1)      check_w($sformatf("r%0d_ch%0d", r, c), d, exp_w[c]);
                else if (ex == 0) check($sformatf("r%0d_ch%0d", r, c), d, 32'h0);
            end
            expv = '0; mask = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                exp_state(c, ex);
                if (ex != 2) mask[c] = 1'b1;
                if (ex == 1) expv[c] = 1'b1;
            end
            rd(6, d);
            check($sformatf("r%0d_status", r), {d[31:14], d[7:6], d[13:8], d[5:0] & mask},
                  {20'h0, exp_err, expv & mask});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
